// File: rtl/execute_alu_md_pkg.sv
// execute_alu_md_pkg: shared widths, op/class codes, mul/div FSM states and op decode helpers
package execute_alu_md_pkg;
  localparam int ALU_OP_W = 8;
  localparam int ALU_SEL_W = 3;
  localparam int REG_ADDR_W = 5;
  localparam logic [ALU_SEL_W-1:0] SEL_LOGIC = 3'd1;
  localparam logic [ALU_SEL_W-1:0] SEL_SHIFT = 3'd2;
  localparam logic [ALU_SEL_W-1:0] SEL_ARITH = 3'd3;
  localparam logic [ALU_SEL_W-1:0] SEL_JUMP_BRANCH = 3'd4;
  localparam logic [ALU_SEL_W-1:0] SEL_LOAD_STORE = 3'd5;
  localparam logic [ALU_SEL_W-1:0] SEL_MULDIV = 3'd6;
  localparam logic [ALU_OP_W-1:0] OP_AND = 8'h01;
  localparam logic [ALU_OP_W-1:0] OP_OR = 8'h02;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 8'h03;
  localparam logic [ALU_OP_W-1:0] OP_NOR = 8'h04;
  localparam logic [ALU_OP_W-1:0] OP_SLL = 8'h05;
  localparam logic [ALU_OP_W-1:0] OP_SRL = 8'h06;
  localparam logic [ALU_OP_W-1:0] OP_SRA = 8'h07;
  localparam logic [ALU_OP_W-1:0] OP_ADD = 8'h08;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 8'h09;
  localparam logic [ALU_OP_W-1:0] OP_SLT = 8'h0A;
  localparam logic [ALU_OP_W-1:0] OP_SLTU = 8'h0B;
  localparam logic [ALU_OP_W-1:0] OP_MUL = 8'h10;
  localparam logic [ALU_OP_W-1:0] OP_MULH = 8'h11;
  localparam logic [ALU_OP_W-1:0] OP_MULHSU = 8'h12;
  localparam logic [ALU_OP_W-1:0] OP_MULHU = 8'h13;
  localparam logic [ALU_OP_W-1:0] OP_DIV = 8'h14;
  localparam logic [ALU_OP_W-1:0] OP_DIVU = 8'h15;
  localparam logic [ALU_OP_W-1:0] OP_REM = 8'h16;
  localparam logic [ALU_OP_W-1:0] OP_REMU = 8'h17;
  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_BUSY = 2'd1, MD_DONE = 2'd2} md_state_e;
  function automatic logic is_md_op(input logic [ALU_OP_W-1:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction
  function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction
  function automatic logic a_signed(input logic [ALU_OP_W-1:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction
  function automatic logic b_signed(input logic [ALU_OP_W-1:0] op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction
endpackage

// File: rtl/execute_alu_md_muldiv_iter.sv
// muldiv_iter: iterative shift-add multiplier and restoring divider on magnitudes, with sign fix-up
module muldiv_iter
  import execute_alu_md_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int MUL_RADIX = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                start_i,
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [XLEN-1:0]     result_o
);
  localparam int CW = $clog2(XLEN);
  localparam int B = MUL_RADIX;
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / B - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
  md_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic sa, sb, div_q, last, ge, negp;
  logic [XLEN-1:0] abs_a, abs_b, sub, quo, rem;
  logic [XLEN+B-1:0] mac;
  logic [XLEN:0] shl;
  logic [2*XLEN-1:0] prod;
  assign sa = a_signed(op_i) & a_i[XLEN-1];
  assign sb = b_signed(op_i) & b_i[XLEN-1];
  assign abs_a = sa ? -a_i : a_i;
  assign abs_b = sb ? -b_i : b_i;
  assign div_q = is_div_op(op_q);
  assign last = cnt_q == (div_q ? DIV_LAST : MUL_LAST);
  assign mac = {{B{1'b0}}, hi_q} + {{B{1'b0}}, m_q} * {{XLEN{1'b0}}, lo_q[B-1:0]};
  assign shl = {hi_q, lo_q[XLEN-1]};
  assign ge = shl >= {1'b0, m_q};
  assign sub = shl[XLEN-1:0] - m_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    m_d = m_q;
    op_d = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    if (flush_i) state_d = MD_IDLE;
    else if (state_q == MD_IDLE && start_i) begin
      state_d = MD_BUSY;
      cnt_d = '0;
      hi_d = '0;
      lo_d = is_div_op(op_i) ? abs_a : abs_b;
      m_d = is_div_op(op_i) ? abs_b : abs_a;
      op_d = op_i;
      neg_a_d = sa;
      neg_b_d = sb;
    end else if (state_q == MD_BUSY) begin
      hi_d = div_q ? (ge ? sub : shl[XLEN-1:0]) : mac[XLEN+B-1:B];
      lo_d = div_q ? {lo_q[XLEN-2:0], ge} : {mac[B-1:0], lo_q[XLEN-1:B]};
      cnt_d = cnt_q + CW'(1);
      state_d = last ? MD_DONE : MD_BUSY;
    end else if (state_q == MD_DONE) state_d = MD_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= MD_IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      op_q <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q <= m_d;
      op_q <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
    end
  end
  assign negp = neg_a_q ^ neg_b_q;
  assign prod = negp ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo = m_q == '0 ? '1 : (negp ? -lo_q : lo_q);
  assign rem = neg_a_q ? -hi_q : hi_q;
  assign result_o = div_q ? (op_q inside {OP_DIV, OP_DIVU} ? quo : rem)
                          : (op_q == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  assign busy_o = state_q != MD_IDLE;
  assign done_o = state_q == MD_DONE;
endmodule

// File: rtl/execute_alu_md.sv
// execute_alu_md: EX-stage ALU with single-cycle classes and an iterative mul/div that stalls the pipeline
module execute_alu_md
  import execute_alu_md_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int MUL_RADIX = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ALU_OP_W-1:0]   aluop,
  input  logic [ALU_SEL_W-1:0]  alusel,
  input  logic [XLEN-1:0]       opv1,
  input  logic [XLEN-1:0]       opv2,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  input  logic                  we_i,
  input  logic [XLEN-1:0]       link_addr,
  input  logic [XLEN-1:0]       mem_offset,
  output logic [REG_ADDR_W-1:0] reg_waddr_o,
  output logic                  we_o,
  output logic [XLEN-1:0]       reg_wdata,
  output logic                  stallreq,
  output logic [XLEN-1:0]       mem_addr,
  output logic [ALU_OP_W-1:0]   ex_aluop,
  output logic [XLEN-1:0]       rt_data,
  output logic                  md_busy
);
  logic [$clog2(XLEN)-1:0] shamt;
  logic signed [XLEN-1:0] sra_res;
  logic [XLEN-1:0] logic_res, shift_res, arith_res, md_result, res;
  logic md_valid, md_start, md_busy_w, md_done;
  assign shamt = opv2[$clog2(XLEN)-1:0];
  assign sra_res = $signed(opv1) >>> shamt;
  assign logic_res = aluop == OP_AND ? opv1 & opv2 :
                     aluop == OP_OR  ? opv1 | opv2 :
                     aluop == OP_XOR ? opv1 ^ opv2 :
                     aluop == OP_NOR ? ~(opv1 | opv2) : '0;
  assign shift_res = aluop == OP_SLL ? opv1 << shamt :
                     aluop == OP_SRL ? opv1 >> shamt :
                     aluop == OP_SRA ? sra_res : '0;
  assign arith_res = aluop == OP_ADD  ? opv1 + opv2 :
                     aluop == OP_SUB  ? opv1 - opv2 :
                     aluop == OP_SLT  ? {{(XLEN-1){1'b0}}, $signed(opv1) < $signed(opv2)} :
                     aluop == OP_SLTU ? {{(XLEN-1){1'b0}}, opv1 < opv2} : '0;
  assign md_valid = alusel == SEL_MULDIV && is_md_op(aluop);
  assign md_start = md_valid & ~flush;
  muldiv_iter #(.XLEN(XLEN), .MUL_RADIX(MUL_RADIX)) u_md (
    .clk(clk),
    .rst(rst),
    .flush_i(flush),
    .start_i(md_start),
    .op_i(aluop),
    .a_i(opv1),
    .b_i(opv2),
    .busy_o(md_busy_w),
    .done_o(md_done),
    .result_o(md_result)
  );
  assign res = alusel == SEL_LOGIC       ? logic_res :
               alusel == SEL_SHIFT       ? shift_res :
               alusel == SEL_ARITH       ? arith_res :
               alusel == SEL_JUMP_BRANCH ? link_addr :
               alusel == SEL_MULDIV      ? (md_valid & md_done ? md_result : '0) : '0;
  assign reg_wdata = rst ? res : '0;
  assign stallreq = rst & ~flush & (md_busy_w ? ~md_done : md_valid);
  assign we_o = rst & we_i & (~md_valid | (md_done & ~flush));
  assign mem_addr = rst && alusel == SEL_LOAD_STORE ? opv1 + mem_offset : '0;
  assign reg_waddr_o = rst ? reg_waddr_i : '0;
  assign ex_aluop = rst ? aluop : '0;
  assign rt_data = rst ? opv2 : '0;
  assign md_busy = rst & md_busy_w;
endmodule
